full_adder_resp_checker: RTL

Synthesizable response checker for the full_adder datapath. It sits on the output side of the adder. Each cycle it samples the applied operand triple together with the adder's sum/cout and compares them against a golden model. It accumulates error count, first-failure capture and input-space coverage, and signals completion once all 8 input vectors have been observed, so adder checks can run on hardware as well as in simulation.

---
 rtl/fa_chk_pkg.sv | 23 ++
 rtl/full_adder.sv | 17 +
 rtl/full_adder_resp_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types, constants and the golden full-adder function for the
// full_adder response checker.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         NUM_VECTORS = 8;
  localparam logic [7:0] COV_FULL    = 8'hFF;

  // Golden full-adder behaviour, returned as {cout, sum}
  function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
    logic s;
    logic c;
    s = a ^ b ^ cin;
    c = (a & b) | (a & cin) | (b & cin);
    return {c, s};
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, used by the response checker as its reference model.
module full_adder
  import fa_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Reference adder output taken straight from the golden function
  always_comb begin
    {cout, sum} = fa_expected(a, b, cin);
  end

endmodule

// File: rtl/full_adder_resp_checker.sv
// Response checker for the full_adder datapath: compares sampled adder
// outputs with a reference adder, counts errors, captures the first
// failing vector and tracks which of the 8 input vectors have been seen.
module full_adder_resp_checker
  import fa_chk_pkg::*;
#(
  parameter int ERR_CNT_W   = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sample,
  input  logic                 a,
  input  logic                 b,
  input  logic                 cin,
  input  logic                 sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           cov_map,
  output logic                 first_err_valid,
  output logic [2:0]           first_err_vec
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q;
  state_t                 state_d;
  logic                   clear_run;
  logic [2:0]             vec;
  logic [NUM_VECTORS-1:0] vec_onehot;
  logic [NUM_VECTORS-1:0] cov_next;
  logic                   ref_sum;
  logic                   ref_cout;
  logic                   sample_run;
  logic                   sample_err;

  full_adder u_ref (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (ref_sum),
    .cout (ref_cout)
  );

  assign vec        = {a, b, cin};
  assign vec_onehot = 8'b0000_0001 << vec;
  assign cov_next   = cov_map | vec_onehot;
  assign sample_run = (state_q == RUN) && sample;
  assign sample_err = sample_run && ((sum != ref_sum) || (cout != ref_cout));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only launches a run from IDLE or DONE; a run
  // ends on full coverage (counting this sample) or on an error when stopping early
  always_comb begin
    state_d   = state_q;
    clear_run = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          clear_run = 1'b1;
        end
      end
      RUN: begin
        if (sample_run && ((cov_next == COV_FULL) || ((STOP_ON_ERR != 0) && sample_err))) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers: cleared on run launch, updated by every sample taken in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch        <= 1'b0;
      err_count       <= '0;
      cov_map         <= 8'h00;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
    end else if (clear_run) begin
      mismatch        <= 1'b0;
      err_count       <= '0;
      cov_map         <= 8'h00;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
    end else begin
      mismatch <= sample_err;
      if (sample_run) begin
        cov_map <= cov_next;
      end
      if (sample_err) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_ONE;
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= vec;
        end
      end
    end
  end

endmodule
